minimig_cpu_bus_bridge: RTL and testbench

Parametrised CPU-to-chip-bus bridge. It carries 16- or 32-bit CPU accesses onto Minimig's 16-bit synchronous chip bus. A 32-bit request is split into up to two 16-bit chip-bus cycles, each gated by DMA slot availability. The block adds a bus-timeout error and a halt/host takeover port for UserIO. It sits between the CPU core wrapper and Gary/Agnus bus decode, in the 28 MHz `clk` domain.

---
 rtl/minimig_cpu_bus_bridge.sv | 226 ++++++++++++++++++++++
 tb/tb_minimig_cpu_bus_bridge.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/minimig_cpu_bus_bridge.sv
// CPU-to-chip-bus bridge: splits 16/32-bit CPU accesses into slot-gated 16-bit
// chip-bus cycles, with a per-word timeout and a halt/host takeover path.
module minimig_cpu_bus_bridge #(
    parameter int DW      = 16,
    parameter int RD_LAT  = 1,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cpu_req,
    input  logic            cpu_we,
    input  logic [DW/8-1:0] cpu_be,
    input  logic [22:0]     cpu_adr,
    input  logic [DW-1:0]   cpu_wdat,
    output logic [DW-1:0]   cpu_rdat,
    output logic            cpu_ack,
    output logic            cpu_err,
    input  logic            cpu_halt,
    output logic            halt_ack,
    input  logic            host_req,
    input  logic            host_we,
    input  logic [1:0]      host_bs,
    input  logic [22:0]     host_adr,
    input  logic [15:0]     host_wdat,
    output logic [15:0]     host_rdat,
    output logic            host_ack,
    input  logic            bus_slot,
    input  logic            bus_dbr,
    input  logic            bus_nrdy,
    output logic [22:0]     bus_adr,
    output logic            bus_rd,
    output logic            bus_hwr,
    output logic            bus_lwr,
    output logic [15:0]     bus_wdat,
    input  logic [15:0]     bus_rdat,
    output logic            bls
);
    typedef enum logic [2:0] {IDLE, WAIT, STRB, LAT, NEXT, ACK, DONE, HALT} state_t;

    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);
    localparam logic [2:0]  LAT_LAST = 3'(RD_LAT - 1);

    state_t        state_q, state_d;
    logic          host_q, host_d, we_q, we_d, err_q, err_d, idx_q, idx_d;
    logic          rd_q, rd_d, hwr_q, hwr_d, lwr_q, lwr_d;
    logic [3:0]    be_q, be_d;
    logic [15:0]   wlo_q, wlo_d, wd_q, wd_d, hrd_q, hrd_d, cnt_q, cnt_d;
    logic [22:0]   adr_q, adr_d;
    logic [2:0]    lat_q, lat_d;
    logic [DW-1:0] rdat_q, rdat_d;

    logic [3:0]    be_in;
    logic [31:0]   wdat_in;
    logic [1:0]    cur_en;
    logic          grant;

    // A 16-bit CPU is handled as a 32-bit access whose upper word is never enabled.
    assign be_in   = 4'(cpu_be);
    assign wdat_in = 32'(cpu_wdat);
    assign cur_en  = idx_q ? be_q[1:0] : be_q[3:2];
    assign grant   = bus_slot & ~bus_dbr & ~bus_nrdy;

    always_comb begin
        state_d = state_q;
        host_d  = host_q;
        we_d    = we_q;
        err_d   = err_q;
        idx_d   = idx_q;
        be_d    = be_q;
        wlo_d   = wlo_q;
        wd_d    = wd_q;
        hrd_d   = hrd_q;
        cnt_d   = cnt_q;
        adr_d   = adr_q;
        lat_d   = lat_q;
        rdat_d  = rdat_q;
        rd_d    = 1'b0;
        hwr_d   = 1'b0;
        lwr_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_halt && !cpu_req) begin
                    state_d = HALT;
                end else if (cpu_req) begin
                    host_d = 1'b0;
                    err_d  = 1'b0;
                    we_d   = cpu_we;
                    be_d   = be_in;
                    wlo_d  = wdat_in[15:0];
                    cnt_d  = '0;
                    if (be_in[3:2] != 2'b00) begin
                        idx_d = 1'b0;
                        adr_d = cpu_adr;
                        wd_d  = wdat_in[31:16];
                    end else begin
                        idx_d = 1'b1;
                        adr_d = (DW == 32) ? cpu_adr + 23'd1 : cpu_adr;
                        wd_d  = wdat_in[15:0];
                    end
                    state_d = (be_in == 4'b0000) ? ACK : WAIT;
                end
            end
            HALT: begin
                if (host_req) begin
                    host_d  = 1'b1;
                    err_d   = 1'b0;
                    we_d    = host_we;
                    be_d    = {2'b00, host_bs};
                    wlo_d   = host_wdat;
                    idx_d   = 1'b1;
                    adr_d   = host_adr;
                    wd_d    = host_wdat;
                    cnt_d   = '0;
                    state_d = (host_bs == 2'b00) ? ACK : WAIT;
                end else if (!cpu_halt) begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (grant) begin
                    rd_d    = ~we_q;
                    hwr_d   = we_q & cur_en[1];
                    lwr_d   = we_q & cur_en[0];
                    state_d = STRB;
                end else if (TIMEOUT != 0 && cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            STRB: begin
                lat_d   = '0;
                state_d = we_q ? NEXT : LAT;
            end
            LAT: begin
                if (lat_q == LAT_LAST) begin
                    if (host_q)
                        hrd_d = bus_rdat;
                    else if (!idx_q)
                        rdat_d = DW'({bus_rdat, rdat_q[15:0]});
                    else
                        rdat_d = (rdat_q & ~DW'(16'hFFFF)) | DW'(bus_rdat);
                    state_d = NEXT;
                end else begin
                    lat_d = lat_q + 3'd1;
                end
            end
            NEXT: begin
                if (!idx_q && be_q[1:0] != 2'b00) begin
                    idx_d   = 1'b1;
                    adr_d   = adr_q + 23'd1;
                    wd_d    = wlo_q;
                    cnt_d   = '0;
                    state_d = WAIT;
                end else begin
                    state_d = ACK;
                end
            end
            ACK: state_d = DONE;
            DONE: begin
                if (host_q) begin
                    if (!host_req) begin
                        host_d  = 1'b0;
                        state_d = HALT;
                    end
                end else if (!cpu_req) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            host_q  <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= 1'b0;
            be_q    <= '0;
            wlo_q   <= '0;
            wd_q    <= '0;
            hrd_q   <= '0;
            cnt_q   <= '0;
            adr_q   <= '0;
            lat_q   <= '0;
            rdat_q  <= '0;
            rd_q    <= 1'b0;
            hwr_q   <= 1'b0;
            lwr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            host_q  <= host_d;
            we_q    <= we_d;
            err_q   <= err_d;
            idx_q   <= idx_d;
            be_q    <= be_d;
            wlo_q   <= wlo_d;
            wd_q    <= wd_d;
            hrd_q   <= hrd_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            lat_q   <= lat_d;
            rdat_q  <= rdat_d;
            rd_q    <= rd_d;
            hwr_q   <= hwr_d;
            lwr_q   <= lwr_d;
        end
    end

    assign cpu_rdat  = rdat_q;
    assign host_rdat = hrd_q;
    assign bus_adr   = adr_q;
    assign bus_wdat  = wd_q;
    assign bus_rd    = rd_q;
    assign bus_hwr   = hwr_q;
    assign bus_lwr   = lwr_q;
    assign bls       = (state_q == WAIT);
    assign cpu_ack   = (state_q == ACK) && !host_q;
    assign host_ack  = (state_q == ACK) && host_q;
    assign cpu_err   = cpu_ack & err_q;
    assign halt_ack  = (state_q == HALT) || host_q;

endmodule

// File: tb/tb_minimig_cpu_bus_bridge.sv
// Self-checking bench for minimig_cpu_bus_bridge (DW=32, RD_LAT=2, TIMEOUT=8):
// per-access timelines are predicted from grant schedules the bench itself chooses.
module tb_minimig_cpu_bus_bridge;
    localparam int DW      = 32;
    localparam int RD_LAT  = 2;
    localparam int TIMEOUT = 8;
    localparam int NC      = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, cpu_ack, cpu_err, cpu_halt, halt_ack;
    logic [3:0]  cpu_be;
    logic [22:0] cpu_adr;
    logic [31:0] cpu_wdat, cpu_rdat;
    logic        host_req, host_we, host_ack;
    logic [1:0]  host_bs;
    logic [22:0] host_adr;
    logic [15:0] host_wdat, host_rdat;
    logic        bus_slot, bus_dbr, bus_nrdy, bus_rd, bus_hwr, bus_lwr, bls;
    logic [22:0] bus_adr;
    logic [15:0] bus_wdat, bus_rdat;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic        s_slot [NC];
    logic        s_dbr  [NC];
    logic        s_nrdy [NC];
    logic [15:0] rv [2];
    logic [31:0] rdat_model;
    int          obs_ack, obs_strb;

    minimig_cpu_bus_bridge #(.DW(DW), .RD_LAT(RD_LAT), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_adr(cpu_adr),
        .cpu_wdat(cpu_wdat), .cpu_rdat(cpu_rdat), .cpu_ack(cpu_ack), .cpu_err(cpu_err),
        .cpu_halt(cpu_halt), .halt_ack(halt_ack),
        .host_req(host_req), .host_we(host_we), .host_bs(host_bs), .host_adr(host_adr),
        .host_wdat(host_wdat), .host_rdat(host_rdat), .host_ack(host_ack),
        .bus_slot(bus_slot), .bus_dbr(bus_dbr), .bus_nrdy(bus_nrdy), .bus_adr(bus_adr),
        .bus_rd(bus_rd), .bus_hwr(bus_hwr), .bus_lwr(bus_lwr), .bus_wdat(bus_wdat),
        .bus_rdat(bus_rdat), .bls(bls)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_sched(input logic sl, input logic db, input logic nr);
        for (int i = 0; i < NC; i++) begin
            s_slot[i] = sl;
            s_dbr[i]  = db;
            s_nrdy[i] = nr;
        end
        rv[0] = 16'($urandom);
        rv[1] = 16'($urandom);
    endtask

    task automatic rand_sched;
        for (int i = 0; i < NC; i++) begin
            s_slot[i] = 1'($urandom % 2);
            s_dbr[i]  = (($urandom % 4) == 0);
            s_nrdy[i] = (($urandom % 4) == 0);
        end
        rv[0] = 16'($urandom);
        rv[1] = 16'($urandom);
    endtask

    // Predict the access timeline from the schedule, then drive it cycle by cycle.
    task automatic run_access(input logic we, input logic [3:0] be, input logic [22:0] adr,
                              input logic [31:0] wdat, input int halt_cyc);
        logic        e_rd [NC];
        logic        e_hwr[NC];
        logic        e_lwr[NC];
        logic        e_bls[NC];
        logic [22:0] e_adr[NC];
        logic [15:0] e_wd [NC];
        logic [15:0] e_rv [NC];
        logic [31:0] rd_exp;
        logic [1:0]  en;
        logic        err, found, strb;
        int          t, c, ack_cyc;
        for (int i = 0; i < NC; i++) begin
            e_rd[i] = 0; e_hwr[i] = 0; e_lwr[i] = 0; e_bls[i] = 0;
            e_adr[i] = '0; e_wd[i] = '0; e_rv[i] = '0;
        end
        rd_exp  = rdat_model;
        err     = 0;
        t       = 1;
        ack_cyc = 1;
        for (int w = 0; w < 2; w++) begin
            en = (w == 0) ? be[3:2] : be[1:0];
            if (en != 2'b00 && !err) begin
                found = 0;
                c     = t;
                for (int k = 0; k < TIMEOUT; k++) begin
                    if (!found && s_slot[t+k] && !s_dbr[t+k] && !s_nrdy[t+k]) begin
                        found = 1;
                        c     = t + k;
                    end
                end
                if (!found) begin
                    for (int k = t; k < t + TIMEOUT; k++) e_bls[k] = 1;
                    err     = 1;
                    ack_cyc = t + TIMEOUT;
                end else begin
                    for (int k = t; k <= c; k++) e_bls[k] = 1;
                    e_adr[c+1] = (w == 0) ? adr : adr + 23'd1;
                    e_wd[c+1]  = (w == 0) ? wdat[31:16] : wdat[15:0];
                    e_rv[c+1]  = rv[w];
                    if (we) begin
                        e_hwr[c+1] = en[1];
                        e_lwr[c+1] = en[0];
                        t = c + 3;
                    end else begin
                        e_rd[c+1] = 1;
                        t = c + 3 + RD_LAT;
                        if (w == 0) rd_exp[31:16] = rv[0];
                        else        rd_exp[15:0]  = rv[1];
                    end
                    ack_cyc = t;
                end
            end
        end

        obs_ack  = -1;
        obs_strb = -1;
        cpu_we   = we;
        cpu_be   = be;
        cpu_adr  = adr;
        cpu_wdat = wdat;
        cpu_req  = 1;
        for (int cyc = 0; cyc <= ack_cyc + 1; cyc++) begin
            bus_slot = s_slot[cyc];
            bus_dbr  = s_dbr[cyc];
            bus_nrdy = s_nrdy[cyc];
            if (cyc == halt_cyc) cpu_halt = 1;
            if (e_rd[cyc]) bus_rdat = e_rv[cyc];
            if (cyc == ack_cyc + 1) cpu_req = 0;
            @(negedge clk);
            strb = e_rd[cyc] | e_hwr[cyc] | e_lwr[cyc];
            n_tests++;
            if (cpu_ack !== (cyc == ack_cyc)) begin
                n_fail++; $display("FAIL cpu_ack cyc=%0d got=%b exp=%b", cyc, cpu_ack, (cyc == ack_cyc));
            end
            n_tests++;
            if (cpu_err !== (cyc == ack_cyc && err)) begin
                n_fail++; $display("FAIL cpu_err cyc=%0d got=%b exp=%b", cyc, cpu_err, (cyc == ack_cyc && err));
            end
            n_tests++;
            if ({bus_rd, bus_hwr, bus_lwr} !== {e_rd[cyc], e_hwr[cyc], e_lwr[cyc]}) begin
                n_fail++; $display("FAIL strobes cyc=%0d got=%b%b%b exp=%b%b%b", cyc, bus_rd, bus_hwr, bus_lwr, e_rd[cyc], e_hwr[cyc], e_lwr[cyc]);
            end
            n_tests++;
            if (bls !== e_bls[cyc]) begin
                n_fail++; $display("FAIL bls cyc=%0d got=%b exp=%b", cyc, bls, e_bls[cyc]);
            end
            n_tests++;
            if (halt_ack !== 1'b0) begin
                n_fail++; $display("FAIL halt_ack_busy cyc=%0d got=%b exp=0", cyc, halt_ack);
            end
            if (strb) begin
                n_tests++;
                if (bus_adr !== e_adr[cyc]) begin
                    n_fail++; $display("FAIL bus_adr cyc=%0d got=%h exp=%h", cyc, bus_adr, e_adr[cyc]);
                end
                if (we) begin
                    n_tests++;
                    if (bus_wdat !== e_wd[cyc]) begin
                        n_fail++; $display("FAIL bus_wdat cyc=%0d got=%h exp=%h", cyc, bus_wdat, e_wd[cyc]);
                    end
                end
            end
            if (cyc == 0) begin
                n_tests++;
                if (cpu_rdat !== rdat_model) begin
                    n_fail++; $display("FAIL rdat_hold got=%h exp=%h", cpu_rdat, rdat_model);
                end
            end
            if (cyc == ack_cyc) begin
                n_tests++;
                if (cpu_rdat !== rd_exp) begin
                    n_fail++; $display("FAIL cpu_rdat got=%h exp=%h", cpu_rdat, rd_exp);
                end
            end
            if (cpu_ack === 1'b1 && obs_ack < 0) obs_ack = cyc;
            if ((bus_rd | bus_hwr | bus_lwr) === 1'b1 && obs_strb < 0) obs_strb = cyc;
            tick;
        end
        rdat_model = rd_exp;
        bus_slot = 0;
        bus_dbr  = 0;
        bus_nrdy = 0;
        tick;
    endtask

    task automatic test_reset;
        n_tests++;
        if ({bus_rd, bus_hwr, bus_lwr, cpu_ack, cpu_err, host_ack, halt_ack, bls} !== 8'h00) begin
            n_fail++; $display("FAIL reset_ctrl got=%b exp=00000000", {bus_rd, bus_hwr, bus_lwr, cpu_ack, cpu_err, host_ack, halt_ack, bls});
        end
        n_tests++;
        if ({cpu_rdat, host_rdat, bus_adr, bus_wdat} !== '0) begin
            n_fail++; $display("FAIL reset_data got=%h/%h/%h/%h exp=0", cpu_rdat, host_rdat, bus_adr, bus_wdat);
        end
    endtask

    task automatic test_write_slot4;
        set_sched(0, 0, 0);
        s_slot[4] = 1;
        run_access(1, 4'b1000, 23'h000100, 32'hA55A_0000, -1);
        n_tests++;
        if (obs_strb !== 5) begin
            n_fail++; $display("FAIL w16_strobe_cycle got=%0d exp=5", obs_strb);
        end
        n_tests++;
        if (obs_ack !== 7) begin
            n_fail++; $display("FAIL w16_ack_cycle got=%0d exp=7", obs_ack);
        end
    endtask

    task automatic test_read32_wrap;
        set_sched(1, 0, 0);
        rv[0] = 16'h1234;
        rv[1] = 16'h5678;
        run_access(0, 4'hF, 23'h7FFFFF, 32'($urandom), -1);
        n_tests++;
        if (cpu_rdat !== 32'h1234_5678) begin
            n_fail++; $display("FAIL r32_wrap_data got=%h exp=12345678", cpu_rdat);
        end
    endtask

    task automatic test_partial_write;
        set_sched(1, 0, 0);
        run_access(1, 4'b0011, 23'($urandom), 32'($urandom), -1);
        n_tests++;
        if (obs_strb !== 2 || obs_ack !== 4) begin
            n_fail++; $display("FAIL lower_only_timing got=%0d/%0d exp=2/4", obs_strb, obs_ack);
        end
        run_access(1, 4'b0000, 23'($urandom), 32'($urandom), -1);
        n_tests++;
        if (obs_strb !== -1) begin
            n_fail++; $display("FAIL no_enable_strobe got=%0d exp=-1", obs_strb);
        end
    endtask

    task automatic test_timeout;
        set_sched(1, 1, 0);
        run_access(1, 4'hF, 23'($urandom), 32'($urandom), -1);
        n_tests++;
        if (obs_ack !== 9 || obs_strb !== -1) begin
            n_fail++; $display("FAIL timeout got=%0d/%0d exp=9/-1", obs_ack, obs_strb);
        end
    endtask

    task automatic test_random;
        logic [22:0] a;
        for (int i = 0; i < 40; i++) begin
            rand_sched;
            a = (($urandom % 4) == 0) ? 23'h7FFFFF : 23'($urandom);
            run_access(1'($urandom % 2), 4'($urandom), a, 32'($urandom), -1);
        end
    endtask

    task automatic test_halt_host;
        logic [22:0] ha;
        logic [15:0] hv;
        int          waited, nstrb;
        logic        got_ack;
        set_sched(1, 0, 0);
        run_access(0, 4'hF, 23'($urandom), 32'($urandom), 2);
        waited = 0;
        while (halt_ack !== 1'b1 && waited < 6) begin
            tick;
            waited++;
        end
        n_tests++;
        if (halt_ack !== 1'b1) begin
            n_fail++; $display("FAIL halt_entry got=%b exp=1", halt_ack);
        end
        ha        = 23'($urandom);
        hv        = 16'($urandom);
        cpu_we    = 1;
        cpu_be    = 4'hC;
        cpu_adr   = 23'($urandom);
        cpu_wdat  = 32'($urandom);
        cpu_req   = 1;
        host_we   = 0;
        host_bs   = 2'b11;
        host_adr  = ha;
        host_req  = 1;
        bus_slot  = 1;
        bus_rdat  = hv;
        for (int cyc = 0; cyc < 14; cyc++) begin
            if (cyc == 8) host_req = 0;
            @(negedge clk);
            n_tests++;
            if (host_ack !== (cyc == 6)) begin
                n_fail++; $display("FAIL host_ack cyc=%0d got=%b exp=%b", cyc, host_ack, (cyc == 6));
            end
            n_tests++;
            if ({bus_rd, bus_hwr, bus_lwr, cpu_ack, halt_ack} !== {(cyc == 2), 3'b000, 1'b1}) begin
                n_fail++; $display("FAIL host_ctrl cyc=%0d got=%b%b%b%b%b", cyc, bus_rd, bus_hwr, bus_lwr, cpu_ack, halt_ack);
            end
            if (cyc == 2) begin
                n_tests++;
                if (bus_adr !== ha) begin
                    n_fail++; $display("FAIL host_adr got=%h exp=%h", bus_adr, ha);
                end
            end
            if (cyc == 6) begin
                n_tests++;
                if (host_rdat !== hv) begin
                    n_fail++; $display("FAIL host_rdat got=%h exp=%h", host_rdat, hv);
                end
            end
            tick;
        end
        cpu_halt = 0;
        got_ack  = 0;
        nstrb    = 0;
        for (int k = 0; k < 40 && !got_ack; k++) begin
            tick;
            if (bus_hwr === 1'b1 && bus_lwr === 1'b1 && bus_adr === cpu_adr) nstrb++;
            if (cpu_ack === 1'b1) got_ack = 1;
        end
        n_tests++;
        if (!got_ack || nstrb !== 1) begin
            n_fail++; $display("FAIL resume_after_halt got=ack%0d/strb%0d exp=ack1/strb1", got_ack, nstrb);
        end
        cpu_req  = 0;
        bus_slot = 0;
        tick;
        tick;
    endtask

    task automatic test_reset_in_lat;
        logic seen;
        cpu_we   = 0;
        cpu_be   = 4'hF;
        cpu_adr  = 23'($urandom);
        cpu_req  = 1;
        bus_slot = 1;
        bus_rdat = 16'($urandom);
        tick;
        tick;
        tick;
        rst     = 1;
        cpu_req = 0;
        tick;
        rst = 0;
        @(negedge clk);
        test_reset;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            tick;
            if (cpu_ack === 1'b1 || bus_rd === 1'b1) seen = 1;
        end
        n_tests++;
        if (seen !== 1'b0) begin
            n_fail++; $display("FAIL reset_no_ack got=%b exp=0", seen);
        end
        bus_slot   = 0;
        rdat_model = '0;
        rand_sched;
        run_access(0, 4'hF, 23'($urandom), 32'($urandom), -1);
    endtask

    initial begin
        rst = 1; cpu_req = 0; cpu_we = 0; cpu_be = '0; cpu_adr = '0; cpu_wdat = '0; cpu_halt = 0;
        host_req = 0; host_we = 0; host_bs = '0; host_adr = '0; host_wdat = '0;
        bus_slot = 0; bus_dbr = 0; bus_nrdy = 0; bus_rdat = '0;
        rdat_model = '0;
        tick;
        tick;
        tick;
        rst = 0;
        tick;
        test_reset;
        test_write_slot4;
        test_read32_wrap;
        test_partial_write;
        test_timeout;
        test_random;
        test_halt_host;
        test_reset_in_lat;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
